// File: rtl/board_ctrl.sv
// board_ctrl: 7x6 drop-piece game board; sole writer of the 98-bit grid read by the VGA display.
// Define DROP_ANIM_EN to replace the instant column scan with a timed falling animation (ANIM_TICKS per row).
module board_ctrl #(
    parameter int ANIM_TICKS = 25000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_drop,
    output logic [97:0] grid,
    output logic        turn,
    output logic        busy,
    output logic        illegal,
    output logic        game_over,
    output logic [1:0]  winner
);
    // state   | meaning
    // S_IDLE  | waiting for buttons, selection cursor shown
    // S_DROP  | piece travelling down the column (SCAN, or FALL when animated)
    // S_CHECK | one line direction evaluated per cycle, four cycles
    // S_OVER  | board frozen until btn_drop restarts the game
    typedef enum logic [1:0] {S_IDLE, S_DROP, S_CHECK, S_OVER} state_t;

    state_t     state, state_nxt;
    logic [1:0] board [0:5][0:6];
    logic [2:0] cursor, col, row;
    logic [1:0] dir;
    logic [5:0] move_cnt;
    logic       win_flag;
    logic [1:0] player;
    logic       accept, bad_drop, mv_left, mv_right, land, restart, line_win, finish;
`ifdef DROP_ANIM_EN
    logic [24:0] tick;
    logic        tick_done, below_empty;

    assign tick_done   = (tick == 25'(ANIM_TICKS - 1));
    assign below_empty = (row != 3'd5) && (board[row + 3'd1][col] == 2'b00);
`endif

    assign player = turn ? 2'b10 : 2'b01;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        bad_drop  = 1'b0;
        mv_left   = 1'b0;
        mv_right  = 1'b0;
        land      = 1'b0;
        restart   = 1'b0;
        finish    = 1'b0;
        case (state)
            S_IDLE: begin
                if (btn_drop) begin
                    if (board[0][cursor] != 2'b00) bad_drop = 1'b1;
                    else begin
                        accept    = 1'b1;
                        state_nxt = S_DROP;
                    end
                end else if (btn_left && !btn_right) mv_left = 1'b1;
                else if (btn_right && !btn_left)     mv_right = 1'b1;
            end
            S_DROP: begin
`ifdef DROP_ANIM_EN
                if (tick_done && !below_empty) begin
`else
                if (board[row][col] == 2'b00) begin
`endif
                    land      = 1'b1;
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (dir == 2'd3) begin
                    finish = 1'b1;
                    if (win_flag || line_win || move_cnt == 6'd42) state_nxt = S_OVER;
                    else                                          state_nxt = S_IDLE;
                end
            end
            S_OVER: begin
                if (btn_drop) begin
                    restart   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Run length through the placed cell along the direction selected by dir.
    always_comb begin
        int dr, dc, r, c, cnt;
        logic run, hit;
        dr  = 0;
        dc  = 1;
        r   = 0;
        c   = 0;
        cnt = 1;
        run = 1'b0;
        hit = 1'b0;
        case (dir)
            2'd0:    begin dr = 0;  dc = 1; end
            2'd1:    begin dr = 1;  dc = 0; end
            2'd2:    begin dr = 1;  dc = 1; end
            default: begin dr = -1; dc = 1; end
        endcase
        for (int s = -1; s <= 1; s += 2) begin
            run = 1'b1;
            for (int k = 1; k <= 3; k++) begin
                r   = int'(row) + s * k * dr;
                c   = int'(col) + s * k * dc;
                hit = 1'b0;
                for (int i = 0; i < 6; i++)
                    for (int j = 0; j < 7; j++)
                        if (i == r && j == c && board[i][j] == player) hit = 1'b1;
                if (run && hit) cnt = cnt + 1;
                else            run = 1'b0;
            end
        end
        line_win = (cnt >= 4);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 6; r++)
                for (int c = 0; c < 7; c++)
                    board[r][c] <= 2'b00;
            cursor   <= 3'd3;
            col      <= 3'd0;
            row      <= 3'd0;
            dir      <= 2'd0;
            move_cnt <= 6'd0;
            win_flag <= 1'b0;
            turn     <= 1'b0;
            winner   <= 2'b00;
            illegal  <= 1'b0;
`ifdef DROP_ANIM_EN
            tick     <= 25'd0;
`endif
        end else begin
            illegal <= bad_drop;
            if (mv_left)  cursor <= (cursor == 3'd0) ? 3'd6 : cursor - 3'd1;
            if (mv_right) cursor <= (cursor == 3'd6) ? 3'd0 : cursor + 3'd1;
            if (accept) begin
                col      <= cursor;
                dir      <= 2'd0;
                win_flag <= 1'b0;
`ifdef DROP_ANIM_EN
                row              <= 3'd0;
                tick             <= 25'd0;
                board[0][cursor] <= player;
                move_cnt         <= move_cnt + 6'd1;
`else
                row <= 3'd5;
`endif
            end
            if (state == S_DROP) begin
`ifdef DROP_ANIM_EN
                if (tick_done) begin
                    tick <= 25'd0;
                    if (below_empty) begin
                        board[row][col]        <= 2'b00;
                        board[row + 3'd1][col] <= player;
                        row                    <= row + 3'd1;
                    end
                end else tick <= tick + 25'd1;
`else
                if (land) begin
                    board[row][col] <= player;
                    move_cnt        <= move_cnt + 6'd1;
                end else row <= row - 3'd1;
`endif
            end
            if (state == S_CHECK) begin
                dir      <= dir + 2'd1;
                win_flag <= win_flag | line_win;
                if (finish) begin
                    if (win_flag || line_win)   winner <= player;
                    else if (move_cnt == 6'd42) winner <= 2'b11;
                    else                        turn   <= ~turn;
                end
            end
            if (restart) begin
                for (int r = 0; r < 6; r++)
                    for (int c = 0; c < 7; c++)
                        board[r][c] <= 2'b00;
                move_cnt <= 6'd0;
                winner   <= 2'b00;
                cursor   <= 3'd3;
                turn     <= 1'b0;
            end
        end
    end

    always_comb begin
        grid = '0;
        for (int c = 0; c < 7; c++) begin
            if (state == S_IDLE && int'(cursor) == c) grid[97-2*c -: 2] = player;
            for (int r = 0; r < 6; r++) grid[83-14*r-2*c -: 2] = board[r][c];
        end
    end

    assign busy      = (state == S_DROP) || (state == S_CHECK);
    assign game_over = (state == S_OVER);
endmodule
